// File: rtl/regfile_sb_if.sv
// Register file bus: decode-side reads/issue plus writeback.
// Decode/writeback drive as master; the register file is the slave.
interface regfile_sb_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              RegWrite;
  logic [ADDR_W-1:0] rd;
  logic [XLEN-1:0]   rd_write_data;
  logic              Issue;
  logic [ADDR_W-1:0] issue_rd;
  logic              ready;

  modport master (
    output rs1, rs2, RegWrite, rd,
    output rd_write_data, Issue, issue_rd,
    input  rs1_data, rs2_data,
    input  rs1_busy, rs2_busy, ready
  );

  modport slave (
    input  rs1, rs2, RegWrite, rd,
    input  rd_write_data, Issue, issue_rd,
    output rs1_data, rs2_data,
    output rs1_busy, rs2_busy, ready
  );
endinterface

// File: rtl/regfile_sb.sv
// 2R/1W register file with post-reset clear sequence,
// optional x0 hardwire, write bypass and busy scoreboard.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST =
    (ADDR_W+1)'(NREGS - 1);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_clr_idx;
  logic [XLEN-1:0]   r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;

  logic              w_rdy;
  logic              w_wr;
  logic              w_iss;
  logic [ADDR_W-1:0] w_ra    [2];
  logic [XLEN-1:0]   w_rdata [2];
  logic              w_rbusy [2];

  assign w_rdy = (r_state == S_READY);

  assign w_wr  = w_rdy && bus.RegWrite &&
                 !(ZERO_REG != 0 && bus.rd == '0);
  assign w_iss = w_rdy && bus.Issue &&
                 !(ZERO_REG != 0 && bus.issue_rd == '0);

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_CLEAR && r_clr_idx == LAST)
      w_state_nxt = S_READY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR)
        r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  // Array has no reset; the clear walk zeroes it one entry per edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR)
        r_regs[r_clr_idx[ADDR_W-1:0]] <= '0;
      else if (w_wr)
        r_regs[bus.rd] <= bus.rd_write_data;
    end
  end

  // Issue is applied after the write so a newer producer stays busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (w_wr)
        r_busy[bus.rd] <= 1'b0;
      if (w_iss)
        r_busy[bus.issue_rd] <= 1'b1;
    end
  end

  assign w_ra[0] = bus.rs1;
  assign w_ra[1] = bus.rs2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdata[p] = '0;
      w_rbusy[p] = 1'b0;
      if (!w_rdy) begin
        w_rdata[p] = '0;
        w_rbusy[p] = 1'b0;
      end else if (ZERO_REG != 0 && w_ra[p] == '0) begin
        w_rdata[p] = '0;
        w_rbusy[p] = 1'b0;
      end else if (BYPASS != 0 && w_wr &&
                   bus.rd == w_ra[p]) begin
        w_rdata[p] = bus.rd_write_data;
        w_rbusy[p] = w_iss && (bus.issue_rd == w_ra[p]);
      end else begin
        w_rdata[p] = r_regs[w_ra[p]];
        w_rbusy[p] = r_busy[w_ra[p]];
      end
    end
  end

  assign bus.rs1_data = w_rdata[0];
  assign bus.rs2_data = w_rdata[1];
  assign bus.rs1_busy = w_rbusy[0];
  assign bus.rs2_busy = w_rbusy[1];
  assign bus.ready    = w_rdy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: vector table, corner sequences and
// random traffic against a behavioural model, bypass on and off.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .ADDR_W(5)) b0 ();
  regfile_sb_if #(.XLEN(32), .ADDR_W(5)) b1 ();

  assign b1.rs1           = b0.rs1;
  assign b1.rs2           = b0.rs2;
  assign b1.RegWrite      = b0.RegWrite;
  assign b1.rd            = b0.rd;
  assign b1.rd_write_data = b0.rd_write_data;
  assign b1.Issue         = b0.Issue;
  assign b1.issue_rd      = b0.issue_rd;

  regfile_sb #(.XLEN(32), .ADDR_W(5),
    .ZERO_REG(1), .BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave));

  regfile_sb #(.XLEN(32), .ADDR_W(5),
    .ZERO_REG(1), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));

  // Behavioural model: state after each edge.
  logic [31:0] m_reg  [32];
  bit          m_busy [32];
  bit          m_ready;
  int          m_cnt;

  task automatic model_edge();
    if (rst) begin
      m_ready = 0;
      m_cnt   = 0;
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 32) begin
        m_ready = 1;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
      end
    end else begin
      if (b0.RegWrite && b0.rd != 0) begin
        m_reg[b0.rd]  = b0.rd_write_data;
        m_busy[b0.rd] = 0;
      end
      if (b0.Issue && b0.issue_rd != 0)
        m_busy[b0.issue_rd] = 1;
    end
  endtask

  task automatic exp_read(input logic [4:0] a,
                          input bit bp,
                          output logic [31:0] d,
                          output bit bz);
    d  = '0;
    bz = 0;
    if (m_ready && a != 0) begin
      if (bp && b0.RegWrite && b0.rd == a) begin
        d  = b0.rd_write_data;
        bz = b0.Issue && b0.issue_rd == a;
      end else begin
        d  = m_reg[a];
        bz = m_busy[a];
      end
    end
  endtask

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] d;
    bit bz;
    exp_read(b0.rs1, 1, d, bz);
    cmp("u0.rs1_data", b0.rs1_data, d);
    cmp("u0.rs1_busy", 32'(b0.rs1_busy), 32'(bz));
    exp_read(b0.rs2, 1, d, bz);
    cmp("u0.rs2_data", b0.rs2_data, d);
    cmp("u0.rs2_busy", 32'(b0.rs2_busy), 32'(bz));
    exp_read(b0.rs1, 0, d, bz);
    cmp("u1.rs1_data", b1.rs1_data, d);
    cmp("u1.rs1_busy", 32'(b1.rs1_busy), 32'(bz));
    exp_read(b0.rs2, 0, d, bz);
    cmp("u1.rs2_data", b1.rs2_data, d);
    cmp("u1.rs2_busy", 32'(b1.rs2_busy), 32'(bz));
    cmp("u0.ready", 32'(b0.ready), 32'(m_ready));
    cmp("u1.ready", 32'(b1.ready), 32'(m_ready));
  endtask

  // Drive at negedge, check comb outputs, then take the edge.
  task automatic step(input logic r,
                      input logic [4:0] a1, a2,
                      input logic we,
                      input logic [4:0] wrd,
                      input logic [31:0] wd,
                      input logic iss,
                      input logic [4:0] ird,
                      input bit chk);
    @(negedge clk);
    rst              = r;
    b0.rs1           = a1;
    b0.rs2           = a2;
    b0.RegWrite      = we;
    b0.rd            = wrd;
    b0.rd_write_data = wd;
    b0.Issue         = iss;
    b0.issue_rd      = ird;
    #1;
    if (chk) check_model();
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input logic [4:0] a1, a2);
    step(0, a1, a2, 0, 0, 0, 0, 0, 1);
  endtask

  // Run the clear walk, checking ready only on the 32nd edge.
  task automatic clear_walk(input string nm);
    for (int k = 1; k <= 32; k++) begin
      if (k == 10)
        step(0, 3, 31, 1, 3, 32'hFF, 1, 3, 1);
      else
        idle(7, 31);
      #1;
      cmp(nm, 32'(b0.ready), 32'(k == 32));
    end
  endtask

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  ird;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
  } vec_t;

  vec_t tv [14];

  initial begin
    tv[0]  = '{5, 0, 1, 5, 32'hDEADBEEF, 0, 0,
               32'hDEADBEEF, 0, 0, 0};
    tv[1]  = '{5, 0, 1, 0, 32'h1234, 0, 0,
               32'hDEADBEEF, 0, 0, 0};
    tv[2]  = '{0, 5, 0, 0, 0, 0, 0,
               0, 32'hDEADBEEF, 0, 0};
    tv[3]  = '{9, 5, 1, 9, 32'hA5A5A5A5, 0, 0,
               32'hA5A5A5A5, 32'hDEADBEEF, 0, 0};
    tv[4]  = '{9, 12, 0, 0, 0, 1, 12,
               32'hA5A5A5A5, 0, 0, 0};
    tv[5]  = '{12, 12, 0, 0, 0, 0, 0,
               0, 0, 1, 1};
    tv[6]  = '{12, 9, 1, 12, 32'h111, 0, 0,
               32'h111, 32'hA5A5A5A5, 0, 0};
    tv[7]  = '{12, 12, 0, 0, 0, 0, 0,
               32'h111, 32'h111, 0, 0};
    tv[8]  = '{1, 3, 1, 12, 32'h222, 1, 12,
               0, 0, 0, 0};
    tv[9]  = '{12, 12, 0, 0, 0, 0, 0,
               32'h222, 32'h222, 1, 1};
    tv[10] = '{0, 0, 0, 0, 0, 1, 0,
               0, 0, 0, 0};
    tv[11] = '{0, 12, 0, 0, 0, 0, 0,
               0, 32'h222, 0, 1};
    tv[12] = '{4, 4, 1, 4, 32'h55, 0, 0,
               32'h55, 32'h55, 0, 0};
    tv[13] = '{4, 4, 0, 0, 0, 1, 4,
               32'h55, 32'h55, 0, 0};

    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_ready = 0;
    m_cnt   = 0;

    // Power-up reset, 3 cycles; first cycle is undefined.
    step(1, 7, 31, 0, 0, 0, 0, 0, 0);
    step(1, 7, 31, 0, 0, 0, 0, 0, 1);
    step(1, 7, 31, 0, 0, 0, 0, 0, 1);
    #1;
    cmp("rst.ready", 32'(b0.ready), 32'd0);
    cmp("rst.busy", 32'(b0.rs1_busy), 32'd0);

    // Clear walk, with a write+issue to x3 at cycle 10.
    clear_walk("clr.ready");
    idle(7, 31);
    idle(3, 3);
    cmp("clr.r3", b0.rs1_data, 32'd0);
    cmp("clr.b3", 32'(b0.rs1_busy), 32'd0);

    // Vector table: constant expectations for the bypassing DUT.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      b0.rs1           = tv[i].rs1;
      b0.rs2           = tv[i].rs2;
      b0.RegWrite      = tv[i].we;
      b0.rd            = tv[i].rd;
      b0.rd_write_data = tv[i].wd;
      b0.Issue         = tv[i].iss;
      b0.issue_rd      = tv[i].ird;
      #1;
      cmp($sformatf("tv%0d.d1", i), b0.rs1_data, tv[i].e1);
      cmp($sformatf("tv%0d.d2", i), b0.rs2_data, tv[i].e2);
      cmp($sformatf("tv%0d.b1", i),
          32'(b0.rs1_busy), 32'(tv[i].eb1));
      cmp($sformatf("tv%0d.b2", i),
          32'(b0.rs2_busy), 32'(tv[i].eb2));
      if (i == 3)
        cmp("nobyp.old", b1.rs1_data, 32'd0);
      check_model();
      @(posedge clk);
      model_edge();
      if (i == 3) begin
        #1;
        cmp("nobyp.new", b1.rs1_data, 32'hA5A5A5A5);
      end
    end

    // Mid-operation reset with x4 = 0x55 and busy.
    @(negedge clk);
    #1;
    cmp("mid.pre.d", b0.rs1_data, 32'h55);
    cmp("mid.pre.b", 32'(b0.rs1_busy), 32'd1);
    step(1, 4, 4, 0, 0, 0, 0, 0, 1);
    #1;
    cmp("mid.ready", 32'(b0.ready), 32'd0);
    cmp("mid.busy", 32'(b0.rs1_busy), 32'd0);
    cmp("mid.data", b0.rs1_data, 32'd0);
    for (int k = 1; k <= 32; k++) begin
      idle(4, 4);
      #1;
      cmp("mid.rdy", 32'(b0.ready), 32'(k == 32));
    end
    idle(4, 4);
    cmp("mid.r4", b0.rs1_data, 32'd0);
    cmp("mid.b4", 32'(b0.rs1_busy), 32'd0);

    // Random traffic, low-index heavy for collisions.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 149) == 0,
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)),
           32'($urandom),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)),
           1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
